// File: rtl/ema_pkg.sv
// Shared types and constants for the external memory arbiter.
package ema_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic SEL_ROM = 1'b0;
   localparam logic SEL_RAM = 1'b1;

   // Index width that stays legal for a single requester.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant wins.
module rr_arbiter #(
   parameter int NUM_CORES = 2,
   parameter int IDX_W     = 1
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [IDX_W-1:0]     last_grant,
   output logic [NUM_CORES-1:0] gnt,
   output logic [IDX_W-1:0]     gnt_idx,
   output logic                 gnt_vld
);

   assign gnt_vld = |req;

   // Walk the ring starting one past the previous winner.
   always_comb begin
      int  c;
      logic found;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      c       = 0;
      for (int k = 1; k <= NUM_CORES; k++) begin
         c = (int'(last_grant) + k) % NUM_CORES;
         if (!found && req[c]) begin
            found   = 1'b1;
            gnt[c]  = 1'b1;
            gnt_idx = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Shared ROM/RAM front end for NUM_CORES requesters with round-robin
// arbitration and registered request/ack handshake.
// Optional: define EMA_ERR_EN to flag ROM writes and out-of-range addresses.
module ext_mem_arbiter
   import ema_pkg::*;
#(
   parameter int NUM_CORES = 2,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 17,
   parameter int RAM_DW    = 16,
   parameter int ROM_AW    = 6,
   parameter int RAM_AW    = 5,
   parameter int MEM_LAT   = 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [NUM_CORES-1:0]        core_we,
   input  logic [NUM_CORES-1:0]        core_sel,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*RAM_DW-1:0] core_wdata,
   output logic [NUM_CORES-1:0]        core_ack,
   output logic [DATA_W-1:0]           core_rdata,
   output logic                        core_err,
   output logic                        busy,
   output logic [ROM_AW-1:0]           rom_addr,
   input  logic [DATA_W-1:0]           rom_q,
   output logic [RAM_AW-1:0]           ram_addr,
   output logic [RAM_DW-1:0]           ram_d,
   output logic                        ram_we,
   input  logic [RAM_DW-1:0]           ram_q
);

   localparam int IDX_W = idx_w(NUM_CORES);
   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   logic [NUM_CORES-1:0][ADDR_W-1:0] addr_a;
   logic [NUM_CORES-1:0][RAM_DW-1:0] wdata_a;
   assign addr_a  = core_addr;
   assign wdata_a = core_wdata;

   state_t                state, state_nx;
   logic [CNT_W-1:0]      cnt, cnt_nx;
   logic [IDX_W-1:0]      gidx, gidx_nx, last_grant, last_nx;
   logic [NUM_CORES-1:0]  gnt_q, gnt_q_nx;
   logic                  l_we, l_we_nx, l_sel, l_sel_nx;
   logic [NUM_CORES-1:0]  ack_nx;
   logic [DATA_W-1:0]     rdata_nx;
   logic                  ram_we_nx;
   logic [ROM_AW-1:0]     rom_addr_nx;
   logic [RAM_AW-1:0]     ram_addr_nx;
   logic [RAM_DW-1:0]     ram_d_nx;

   logic [NUM_CORES-1:0]  a_gnt;
   logic [IDX_W-1:0]      a_idx;
   logic                  a_vld;

   rr_arbiter #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_rr (
      .req        (core_req),
      .last_grant (last_grant),
      .gnt        (a_gnt),
      .gnt_idx    (a_idx),
      .gnt_vld    (a_vld)
   );

   logic [ADDR_W-1:0] addr_c;
   logic [RAM_DW-1:0] wdata_c;
   logic              we_c, sel_c;
   assign addr_c  = addr_a[a_idx];
   assign wdata_c = wdata_a[a_idx];
   assign we_c    = core_we[a_idx];
   assign sel_c   = core_sel[a_idx];

`ifdef EMA_ERR_EN
   logic illegal, err_nx;
   assign illegal = (sel_c == SEL_ROM) ? (we_c || ((addr_c >> ROM_AW) != '0))
                                       : ((addr_c >> RAM_AW) != '0);
`else
   // High address bits are intentionally discarded in this build.
   logic unused_addr;
   assign unused_addr = ^addr_c;
   assign core_err    = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      gidx_nx     = gidx;
      gnt_q_nx    = gnt_q;
      l_we_nx     = l_we;
      l_sel_nx    = l_sel;
      last_nx     = last_grant;
      ack_nx      = '0;
      rdata_nx    = core_rdata;
      ram_we_nx   = 1'b0;
      rom_addr_nx = rom_addr;
      ram_addr_nx = ram_addr;
      ram_d_nx    = ram_d;
`ifdef EMA_ERR_EN
      err_nx      = 1'b0;
`endif
      unique case (state)
         IDLE: if (a_vld) begin
            gidx_nx  = a_idx;
            gnt_q_nx = a_gnt;
            l_we_nx  = we_c;
            l_sel_nx = sel_c;
`ifdef EMA_ERR_EN
            if (illegal) begin
               // Rejected without touching memory; ack immediately.
               state_nx = RESP;
               ack_nx   = a_gnt;
               rdata_nx = '0;
               err_nx   = 1'b1;
            end else
`endif
            begin
               state_nx = ISSUE;
               if (sel_c == SEL_RAM) begin
                  ram_addr_nx = addr_c[RAM_AW-1:0];
                  ram_d_nx    = wdata_c;
                  ram_we_nx   = we_c;
               end else begin
                  rom_addr_nx = addr_c[ROM_AW-1:0];
               end
            end
         end
         ISSUE: begin
            cnt_nx   = CNT_W'(MEM_LAT - 1);
            state_nx = WAIT;
         end
         WAIT: begin
            if (cnt == '0) begin
               state_nx = RESP;
               ack_nx   = gnt_q;
               if (l_we)                  rdata_nx = '0;
               else if (l_sel == SEL_RAM) rdata_nx = DATA_W'(ram_q);
               else                       rdata_nx = rom_q;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         RESP: begin
            last_nx  = gidx;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         gidx       <= '0;
         gnt_q      <= '0;
         l_we       <= 1'b0;
         l_sel      <= 1'b0;
         last_grant <= IDX_W'(NUM_CORES - 1);
         core_ack   <= '0;
         core_rdata <= '0;
         busy       <= 1'b0;
         ram_we     <= 1'b0;
         rom_addr   <= '0;
         ram_addr   <= '0;
         ram_d      <= '0;
`ifdef EMA_ERR_EN
         core_err   <= 1'b0;
`endif
      end else begin
         cnt        <= cnt_nx;
         gidx       <= gidx_nx;
         gnt_q      <= gnt_q_nx;
         l_we       <= l_we_nx;
         l_sel      <= l_sel_nx;
         last_grant <= last_nx;
         core_ack   <= ack_nx;
         core_rdata <= rdata_nx;
         busy       <= (state_nx != IDLE);
         ram_we     <= ram_we_nx;
         rom_addr   <= rom_addr_nx;
         ram_addr   <= ram_addr_nx;
         ram_d      <= ram_d_nx;
`ifdef EMA_ERR_EN
         core_err   <= err_nx;
`endif
      end
   end

endmodule
